// File: rtl/wb_pkg.sv
// Shared widths, register-file geometry and result-source encoding for the writeback slice.
package wb_pkg;
    localparam int WORD_LENGTH_DEFAULT = 32;
    localparam int REG_ADDR_W          = 5;
    localparam int NUM_REGS            = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

    // x0 is hardwired: it is never written and never tracked as pending.
    function automatic logic is_live(reg_addr_t rd);
        return rd != '0;
    endfunction
endpackage

// File: rtl/wb_if.sv
// Writeback unit bus: ALU/load results in, scoreboard issue/query, register-file write out.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface wb_if import wb_pkg::*; #(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
);
    logic                   alu_valid;
    reg_addr_t              alu_rd;
    logic [WORD_LENGTH-1:0] alu_data;

    logic                   ld_valid;
    logic                   ld_ready;
    reg_addr_t              ld_rd;
    logic [WORD_LENGTH-1:0] ld_data;

    logic                   iss_load;
    reg_addr_t              iss_rd;

    reg_addr_t              query_rs1;
    reg_addr_t              query_rs2;
    logic                   stall;

    reg_addr_t              write_add;
    logic [WORD_LENGTH-1:0] write_data;
    logic                   write_enable;

`ifdef WB_FORWARD_EN
    logic                   fwd_rs1_hit;
    logic                   fwd_rs2_hit;
    logic [WORD_LENGTH-1:0] fwd_data1;
    logic [WORD_LENGTH-1:0] fwd_data2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        output iss_load, iss_rd,
        output query_rs1, query_rs2,
        input  stall,
`ifdef WB_FORWARD_EN
        input  fwd_rs1_hit, fwd_rs2_hit, fwd_data1, fwd_data2,
`endif
        input  write_add, write_data, write_enable
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        input  iss_load, iss_rd,
        input  query_rs1, query_rs2,
        output stall,
`ifdef WB_FORWARD_EN
        output fwd_rs1_hit, fwd_rs2_hit, fwd_data1, fwd_data2,
`endif
        output write_add, write_data, write_enable
    );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on load writeback.
// Updates take effect at the next edge; queries are combinational. No backpressure.
module wb_scoreboard import wb_pkg::*; (
    input  logic      clk,
    input  logic      rst,
    input  logic      set_vld,
    input  reg_addr_t set_rd,
    input  logic      clr_vld,
    input  reg_addr_t clr_rd,
    input  reg_addr_t query_rs1,
    input  reg_addr_t query_rs2,
    output logic      pend_rs1,
    output logic      pend_rs2
);
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;

    // Clear first, then set, so a re-issue to the register being retired stays pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_vld) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (set_vld && is_live(set_rd)) begin
            pending_nxt[set_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign pend_rs1 = pending[query_rs1];
    assign pend_rs2 = pending[query_rs2];
endmodule

// File: rtl/writeback_unit.sv
// Writeback arbiter (ALU over load) with a 1-cycle registered register-file write stage and hazard stall.
// Loads are held off by ld_ready=0 while an ALU result is present; WB_FORWARD_EN adds write-stage forwarding.
module writeback_unit import wb_pkg::*; #(
    parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT
) (
    input logic clk,
    input logic rst,
    wb_if.slave bus
);
    typedef struct packed {
        reg_addr_t              rd;
        logic [WORD_LENGTH-1:0] data;
    } res_t;

    wb_src_e                src;
    res_t                   res;
    logic                   ld_acc;
    logic                   wr_live;
    logic                   we;
    reg_addr_t              wa;
    logic [WORD_LENGTH-1:0] wd;
    logic                   pend_rs1;
    logic                   pend_rs2;
    logic                   wb_hit1;
    logic                   wb_hit2;

    always_comb begin
        src = SRC_NONE;
        res = '0;
        if (bus.alu_valid) begin
            src      = SRC_ALU;
            res.rd   = bus.alu_rd;
            res.data = bus.alu_data;
        end else if (bus.ld_valid) begin
            src      = SRC_LD;
            res.rd   = bus.ld_rd;
            res.data = bus.ld_data;
        end
    end

    assign bus.ld_ready = !bus.alu_valid;
    assign ld_acc       = (src == SRC_LD);
    assign wr_live      = (src != SRC_NONE) && is_live(res.rd);

    // Results to x0 are consumed without disturbing the held write address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we <= 1'b0;
            wa <= '0;
            wd <= '0;
        end else begin
            we <= wr_live;
            if (wr_live) begin
                wa <= res.rd;
                wd <= res.data;
            end
        end
    end

    assign bus.write_enable = we;
    assign bus.write_add    = wa;
    assign bus.write_data   = wd;

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_vld   (bus.iss_load),
        .set_rd    (bus.iss_rd),
        .clr_vld   (ld_acc),
        .clr_rd    (bus.ld_rd),
        .query_rs1 (bus.query_rs1),
        .query_rs2 (bus.query_rs2),
        .pend_rs1  (pend_rs1),
        .pend_rs2  (pend_rs2)
    );

    // A source being written this cycle has not reached the register file yet.
    assign wb_hit1 = we && is_live(bus.query_rs1) && (wa == bus.query_rs1);
    assign wb_hit2 = we && is_live(bus.query_rs2) && (wa == bus.query_rs2);

`ifdef WB_FORWARD_EN
    assign bus.stall       = pend_rs1 || pend_rs2;
    assign bus.fwd_rs1_hit = wb_hit1;
    assign bus.fwd_rs2_hit = wb_hit2;
    assign bus.fwd_data1   = wb_hit1 ? wd : '0;
    assign bus.fwd_data2   = wb_hit2 ? wd : '0;
`else
    assign bus.stall       = pend_rs1 || pend_rs2 || wb_hit1 || wb_hit2;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// Directed scenarios plus randomized traffic checked against a register-level reference model.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int WL = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wb_if #(.WORD_LENGTH(WL)) bus();

    writeback_unit #(.WORD_LENGTH(WL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          pend [NUM_REGS];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    bit          ld_held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_stall_one(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (pend[rs]) return 1'b1;
`ifndef WB_FORWARD_EN
        if (m_we && m_wa == rs) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) pend[i] = 1'b0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        ld_held = 1'b0;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
        bus.iss_load  = 1'b0; bus.iss_rd = '0;
        bus.query_rs1 = '0;   bus.query_rs2 = '0;
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle();
        bit          acc;
        bit          lacc;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [4:0]  lrd;
        bit          iss;
        logic [4:0]  ird;
        #1;
        chk("ld_ready", bus.ld_ready, !bus.alu_valid);
        chk("stall", bus.stall, exp_stall_one(bus.query_rs1) || exp_stall_one(bus.query_rs2));
`ifdef WB_FORWARD_EN
        chk("fwd1_hit", bus.fwd_rs1_hit, m_we && bus.query_rs1 != 0 && m_wa == bus.query_rs1);
        chk("fwd2_hit", bus.fwd_rs2_hit, m_we && bus.query_rs2 != 0 && m_wa == bus.query_rs2);
        if (bus.fwd_rs1_hit) chk("fwd1_data", bus.fwd_data1, m_wd);
        if (bus.fwd_rs2_hit) chk("fwd2_data", bus.fwd_data2, m_wd);
`endif
        acc = 1'b0; lacc = 1'b0; rd = '0; d = '0;
        if (bus.alu_valid) begin
            acc = 1'b1; rd = bus.alu_rd; d = bus.alu_data;
        end else if (bus.ld_valid) begin
            acc = 1'b1; lacc = 1'b1; rd = bus.ld_rd; d = bus.ld_data;
        end
        lrd = bus.ld_rd;
        iss = bus.iss_load;
        ird = bus.iss_rd;
        ld_held = bus.ld_valid && bus.alu_valid;
        @(posedge clk);
        m_we = acc && rd != 0;
        if (m_we) begin
            m_wa = rd;
            m_wd = d;
        end
        if (lacc) pend[lrd] = 1'b0;
        if (iss && ird != 0) pend[ird] = 1'b1;
        @(negedge clk);
        chk("write_enable", bus.write_enable, m_we);
        chk("write_add", bus.write_add, m_wa);
        chk("write_data", bus.write_data, m_wd);
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);

        // reset state
        bus.query_rs1 = 5'd3;
        #1;
        chk("rst_we", bus.write_enable, 0);
        chk("rst_wa", bus.write_add, 0);
        chk("rst_wd", bus.write_data, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_ld_ready_idle", bus.ld_ready, 1);
        bus.alu_valid = 1'b1;
        #1;
        chk("rst_ld_ready_alu", bus.ld_ready, 0);
        idle();
        @(negedge clk);
        rst = 1'b1;

        // single ALU write, one cycle only
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_we", bus.write_enable, 1);
        chk("alu_wa", bus.write_add, 5);
        chk("alu_wd", bus.write_data, 32'hDEADBEEF);
        idle();
        cycle();
        chk("alu_we_once", bus.write_enable, 0);

        // ALU and load collide: ALU first, load held and written next
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAAAA0003;
        bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4; bus.ld_data  = 32'hBBBB0004;
        #1;
        chk("coll_ld_ready", bus.ld_ready, 0);
        cycle();
        chk("coll_alu_wa", bus.write_add, 3);
        bus.alu_valid = 1'b0;
        cycle();
        chk("coll_ld_wa", bus.write_add, 4);
        chk("coll_ld_wd", bus.write_data, 32'hBBBB0004);
        idle();

        // load-use stall on x7
        bus.iss_load = 1'b1; bus.iss_rd = 5'd7; bus.query_rs1 = 5'd7;
        cycle();
        bus.iss_load = 1'b0;
        #1;
        chk("ld7_stall", bus.stall, 1);
        cycle();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h0000_7777;
        cycle();
        bus.ld_valid = 1'b0;
        #1;
`ifdef WB_FORWARD_EN
        chk("ld7_stall_wb", bus.stall, 0);
        chk("ld7_fwd_hit", bus.fwd_rs1_hit, 1);
        chk("ld7_fwd_data", bus.fwd_data1, 32'h0000_7777);
`else
        chk("ld7_stall_wb", bus.stall, 1);
`endif
        cycle();
        chk("ld7_stall_clear", bus.stall, 0);
        idle();

        // re-issue to x9 while x9 retires: stays pending
        bus.iss_load = 1'b1; bus.iss_rd = 5'd9;
        cycle();
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9999;
        cycle();
        idle();
        bus.query_rs2 = 5'd9;
        cycle();
        chk("x9_still_pending", bus.stall, 1);
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'h9990;
        cycle();
        idle();

        // x0 writes discarded, x0 never stalls
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
        cycle();
        chk("x0_we", bus.write_enable, 0);
        bus.alu_valid = 1'b0;
        bus.iss_load = 1'b1; bus.iss_rd = 5'd0;
        cycle();
        bus.iss_load = 1'b0;
        #1;
        chk("x0_stall", bus.stall, 0);
        idle();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.alu_valid = ($urandom % 10) < 4;
            bus.alu_rd    = 5'($urandom_range(0, 15));
            bus.alu_data  = $urandom;
            if (!ld_held) begin
                bus.ld_valid = $urandom % 2;
                bus.ld_rd    = 5'($urandom_range(0, 15));
                bus.ld_data  = $urandom;
            end
            bus.iss_load  = ($urandom % 4) == 0;
            bus.iss_rd    = 5'($urandom_range(0, 15));
            bus.query_rs1 = 5'($urandom_range(0, 15));
            bus.query_rs2 = 5'($urandom_range(0, 15));
            cycle();
        end
        idle();

        // reset while a write sits in the output stage
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hCAFE0012;
        bus.iss_load  = 1'b1; bus.iss_rd = 5'd13;
        @(posedge clk);
        #2;
        idle();
        bus.query_rs1 = 5'd13;
        #1;
        chk("mid_we_before", bus.write_enable, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_we", bus.write_enable, 0);
        chk("mid_rst_wa", bus.write_add, 0);
        chk("mid_rst_wd", bus.write_data, 0);
        chk("mid_rst_stall", bus.stall, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        chk("post_rst_we", bus.write_enable, 0);
        chk("post_rst_stall", bus.stall, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter WORD_LENGTH, default 32, data width of all result paths.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 alu_valid  in  1  ALU result present this cycle; always accepted, no ready.
REQ-005 alu_rd  in  5  ALU destination register.
REQ-006 alu_data  in  WORD_LENGTH  ALU result.
REQ-007 ld_valid  in  1  load result offered.
REQ-008 ld_ready  out  1  load result accepted when ld_valid and ld_ready are both high.
REQ-009 ld_rd  in  5  load destination register.
REQ-010 ld_data  in  WORD_LENGTH  load result.
REQ-011 iss_load  in  1  load issued this cycle; marks iss_rd pending.
REQ-012 iss_rd  in  5  destination of issued load.
REQ-013 query_rs1, query_rs2  in  5 each  source registers of the instruction in decode.
REQ-014 stall  out  1  a queried source is pending or unresolvable.
REQ-015 write_add  out  5  register-file write address.
REQ-016 write_data  out  WORD_LENGTH  register-file write data.
REQ-017 write_enable  out  1  register-file write strobe.

Function
REQ-018 Writeback output stage shall be registered; an accepted result appears on write_* exactly 1 cycle after acceptance.
REQ-019 ALU shall have priority; ld_ready shall be low in any cycle alu_valid is high, else high.
REQ-020 A load held off by an ALU result shall keep ld_valid/ld_rd/ld_data stable until accepted.
REQ-021 write_enable shall be high for exactly one cycle per accepted result whose rd is non-zero; results to x0 shall be accepted and discarded (write_enable low).
REQ-022 Scoreboard: 32 pending bits; iss_load with iss_rd!=0 sets bit iss_rd at the next edge; x0 shall never be pending.
REQ-023 Acceptance of a load result clears bit ld_rd at the same edge.
REQ-024 Simultaneous set and clear of the same register shall leave the bit set (new issue wins).
REQ-025 ALU results shall not clear pending bits.
REQ-026 stall shall be combinational: high if query_rs1 or query_rs2 is non-zero and pending.
REQ-027 Idle cycles (no accepted result) shall drive write_enable low; write_add/write_data hold last value.

Reset
REQ-028 While rst is low: write_enable=0, write_add=0, write_data=0, all pending bits=0, stall=0; ld_ready follows REQ-019.
REQ-029 Reset asserted mid-operation shall discard the in-flight output-stage result; no write shall occur on the first edge after release.

Configuration
REQ-030 Macro WB_FORWARD_EN: when defined, outputs fwd_rs1_hit/fwd_rs2_hit (1) and fwd_data1/fwd_data2 (WORD_LENGTH) shall present write_data when write_enable is high and write_add equals the non-zero query register.
REQ-031 Without WB_FORWARD_EN, those ports shall not exist and stall shall additionally assert when a non-zero query register equals write_add while write_enable is high.

Structure
REQ-032 Package wb_pkg shall hold WORD_LENGTH default, REG_ADDR_W=5, NUM_REGS=32.
REQ-033 Scoreboard shall be a sub-module wb_scoreboard (set/clear/query ports); output stage and arbitration stay in writeback_unit.

Verification
REQ-034 alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle write_enable=1, write_add=5, write_data=0xDEADBEEF, one cycle only.
REQ-035 alu_valid and ld_valid same cycle (rd 3, rd 4) -> ld_ready=0; ALU write to x3 at cycle+1, load write to x4 at cycle+2.
REQ-036 iss_load, iss_rd=7; query_rs1=7 -> stall=1 until load rd 7 accepted, stall=0 the cycle after.
REQ-037 iss_load rd 9 in the same cycle a load to rd 9 is accepted -> bit 9 remains set, stall persists.
REQ-038 alu_rd=0, alu_data=0x1234 -> write_enable stays 0; query 0 never stalls.
REQ-039 rst low while write pending -> write_enable=0, all pending cleared, no write after release.
